rx_req_scheduler: RTL

Shares the single PCIe read-request path (RX_REQ/RX_REQ_ACK/TAG/ADDR/LEN) among three requesters: main data, SG-RX list fetch and SG-TX list fetch. Each requester presents a whole transfer as an address and a word length. The scheduler grants one job at a time and splits it into read requests. Each request is bounded by the effective max read request size and never crosses a 4 KB address boundary. It sits between the rx_port_128 requester logic and the TX engine that formats read TLPs.

---
 rtl/rx_req_sched_pkg.sv | 30 +++
 rtl/rx_req_scheduler_if.sv | 11 +
 rtl/rx_req_chunk_calc.sv | 24 ++
 rtl/rx_req_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rx_req_sched_pkg.sv
// Shared types and helpers for the read-request scheduler and its chunk splitter.
package rx_req_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // Requester indices; also the value driven on RX_REQ_TAG.
  localparam logic [1:0] REQ_MAIN = 2'd0;
  localparam logic [1:0] REQ_SGRX = 2'd1;
  localparam logic [1:0] REQ_SGTX = 2'd2;

  // Largest read-size code (4096 bytes = 1024 words).
  localparam logic [2:0] SIZE_MAX = 3'd5;

  // Words per request for a read-size code; codes above 5 act as 5.
  function automatic logic [10:0] max_words(input logic [2:0] size);
    logic [2:0] s;
    s = (size > SIZE_MAX) ? SIZE_MAX : size;
    return 11'd32 << s;
  endfunction

  // Reduce 0..5 to a requester index 0..2.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

endpackage

// File: rtl/rx_req_scheduler_if.sv
// Read-request bus between the scheduler (master) and the TX engine (slave).
interface rx_req_scheduler_if;
  logic        RX_REQ;
  logic        RX_REQ_ACK;
  logic [1:0]  RX_REQ_TAG;
  logic [63:0] RX_REQ_ADDR;
  logic [9:0]  RX_REQ_LEN;

  modport master (output RX_REQ, RX_REQ_TAG, RX_REQ_ADDR, RX_REQ_LEN, input RX_REQ_ACK);
  modport slave  (input RX_REQ, RX_REQ_TAG, RX_REQ_ADDR, RX_REQ_LEN, output RX_REQ_ACK);
endinterface

// File: rtl/rx_req_chunk_calc.sv
// Size of the next request: min of words remaining, max request size and the
// distance to the next 4 KB boundary. Purely combinational.
module rx_req_chunk_calc
  import rx_req_sched_pkg::*;
(
  input  logic [31:0] remain,   // words left in the job
  input  logic [9:0]  addr_wd,  // address bits [11:2]: word offset inside the 4 KB page
  input  logic [2:0]  size,     // effective read-size code
  output logic [10:0] chunk     // 1..1024 words when remain != 0
);
  logic [10:0] bnd_s;
  logic [10:0] maxw_s;
  logic [10:0] rem_cap_s;
  logic [10:0] min_a_s;

  // Three-way minimum; the boundary distance is always 1..1024 words.
  always_comb begin
    bnd_s     = 11'd1024 - {1'b0, addr_wd};
    maxw_s    = max_words(size);
    rem_cap_s = (remain > 32'd1024) ? 11'd1024 : remain[10:0];
    min_a_s   = (rem_cap_s < maxw_s) ? rem_cap_s : maxw_s;
    chunk     = (min_a_s < bnd_s) ? min_a_s : bnd_s;
  end
endmodule

// File: rtl/rx_req_scheduler.sv
// Shares one PCIe read-request path among main data, SG-RX and SG-TX requesters.
// Grants one job at a time and splits it into requests bounded by the effective
// max read size and the 4 KB page boundary.
// Build option: RX_REQ_SCHED_RR_EN selects round-robin arbitration; without it
// the arbitration is fixed priority main > SG-RX > SG-TX.
module rx_req_scheduler
  import rx_req_sched_pkg::*;
#(
  parameter int C_MAX_READ_REQ = 2
) (
  input  logic                CLK,
  input  logic                rRst,
  input  logic [2:0]          CONFIG_MAX_READ_REQUEST_SIZE,
  input  logic [2:0]          REQ_VALID,
  input  logic [191:0]        REQ_ADDR,
  input  logic [95:0]         REQ_LEN,
  output logic [2:0]          REQ_ACK,
  output logic [2:0]          REQ_DONE,
  output logic                BUSY,
  rx_req_scheduler_if.master  rx
);
  localparam logic [2:0] C_MAX_SIZE = (C_MAX_READ_REQ > 5) ? 3'd5 : 3'(C_MAX_READ_REQ);

  state_t      state_r;
  logic [63:0] addr_r;
  logic [31:0] remain_r;
  logic [1:0]  tag_r;
  logic [10:0] chunk_r;
  logic        rx_req_r;
  logic [2:0]  done_r;

  logic [2:0]  size_s;
  logic [10:0] chunk_s;
  logic        gnt_ok_s;
  logic [1:0]  gnt_idx_s;
  logic [61:0] gnt_addr_s;
  logic [31:0] gnt_len_s;
  logic        unused_bits_s;

  // A grant is taken only in IDLE and never in the cycle a REQ_DONE is out.
  assign gnt_ok_s = (state_r == IDLE) && (done_r == 3'b000) && (REQ_VALID != 3'b000) && !rRst;

`ifdef RX_REQ_SCHED_RR_EN
  logic [1:0] ptr_r;

  // Round-robin: first valid requester at or after ptr_r wins.
  always_comb begin
    gnt_idx_s = ptr_r;
    for (int k = 2; k >= 0; k--) begin
      gnt_idx_s = REQ_VALID[wrap3(3'(ptr_r) + 3'(k))] ? wrap3(3'(ptr_r) + 3'(k)) : gnt_idx_s;
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_ff @(posedge CLK or posedge rRst) begin
    if (rRst) begin
      ptr_r <= 2'd0;
    end else if (gnt_ok_s) begin
      ptr_r <= wrap3(3'(gnt_idx_s) + 3'd1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: main, then SG-RX, then SG-TX.
  always_comb begin
    if (REQ_VALID[REQ_MAIN]) begin
      gnt_idx_s = REQ_MAIN;
    end else if (REQ_VALID[REQ_SGRX]) begin
      gnt_idx_s = REQ_SGRX;
    end else begin
      gnt_idx_s = REQ_SGTX;
    end
  end
`endif

  // Select the granted requester's address (word part) and length.
  always_comb begin
    case (gnt_idx_s)
      2'd0:    begin gnt_addr_s = REQ_ADDR[63:2];    gnt_len_s = REQ_LEN[31:0];  end
      2'd1:    begin gnt_addr_s = REQ_ADDR[127:66];  gnt_len_s = REQ_LEN[63:32]; end
      2'd2:    begin gnt_addr_s = REQ_ADDR[191:130]; gnt_len_s = REQ_LEN[95:64]; end
      default: begin gnt_addr_s = 62'd0;             gnt_len_s = 32'd0;          end
    endcase
  end

  // Byte-offset bits of the requester addresses are don't-care by definition.
  assign unused_bits_s = ^{REQ_ADDR[1:0], REQ_ADDR[65:64], REQ_ADDR[129:128], chunk_r[10]};

  // Effective size: the smaller of the negotiated and the hard cap.
  assign size_s = (CONFIG_MAX_READ_REQUEST_SIZE < C_MAX_SIZE) ? CONFIG_MAX_READ_REQUEST_SIZE : C_MAX_SIZE;

  rx_req_chunk_calc u_chunk (
    .remain  (remain_r),
    .addr_wd (addr_r[11:2]),
    .size    (size_s),
    .chunk   (chunk_s)
  );

  // Job FSM: latch a job, size each chunk, hold the request until accepted.
  always_ff @(posedge CLK or posedge rRst) begin
    if (rRst) begin
      state_r  <= IDLE;
      addr_r   <= 64'd0;
      remain_r <= 32'd0;
      tag_r    <= 2'd0;
      chunk_r  <= 11'd0;
      rx_req_r <= 1'b0;
      done_r   <= 3'b000;
    end else begin
      done_r <= 3'b000;
      case (state_r)
        IDLE: begin
          if (gnt_ok_s) begin
            addr_r   <= {gnt_addr_s, 2'b00};
            remain_r <= gnt_len_s;
            tag_r    <= gnt_idx_s;
            if (gnt_len_s == 32'd0) begin
              done_r  <= 3'b001 << gnt_idx_s;
              state_r <= IDLE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          chunk_r  <= chunk_s;
          rx_req_r <= 1'b1;
          state_r  <= ISSUE;
        end
        ISSUE: begin
          if (rx.RX_REQ_ACK) begin
            rx_req_r <= 1'b0;
            addr_r   <= addr_r + {51'd0, chunk_r, 2'b00};
            remain_r <= remain_r - {21'd0, chunk_r};
            if (remain_r == {21'd0, chunk_r}) begin
              done_r  <= 3'b001 << tag_r;
              state_r <= IDLE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        default: begin
          rx_req_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  // The grant acknowledge is the same cycle the job is latched.
  assign REQ_ACK = gnt_ok_s ? (3'b001 << gnt_idx_s) : 3'b000;

  assign REQ_DONE       = done_r;
  assign BUSY           = (state_r != IDLE);
  assign rx.RX_REQ      = rx_req_r;
  assign rx.RX_REQ_TAG  = tag_r;
  assign rx.RX_REQ_ADDR = addr_r;
  assign rx.RX_REQ_LEN  = chunk_r[9:0];
endmodule
